exp_series_ctrl: RTL and testbench
==================================

Name: exp_series_ctrl

Overview:
- Moore FSM controller that sequences the fixed-point series-evaluation datapath. The datapath has Q8.8 registers x, tmp and ans, a shared multiplier, an add/sub unit, an 8-entry coefficient ROM and a tmp<=y comparator.
- On a start pulse it loads operands, then iterates term updates until the term falls to or below threshold y or the term limit is reached, and finally reports done.
- It sits between the top-level handshake and the datapath control pins.

Parameters:
- MAX_TERMS, 8, maximum number of series terms (1..8); the term index drives the ROM select s3.
- SQUARE_X, 0, when 1 insert one cycle that replaces x with x*x before iterating (even-power series).
- ALT_SIGN, 0, when 1 subtract even-indexed terms and add odd-indexed terms (first term subtracted).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- less_cmp  in  1  datapath comparator result (tmp <= y).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- terms  out  4  number of terms accumulated in the last run; held until the next LOAD.
- s1_rom, s1_x  out  1 each  multiplier operand-1 select; s1_x = ~s1_rom.
- s2_x, s2_tmp  out  1 each  multiplier operand-2 select; s2_tmp = ~s2_x.
- s3  out  3  ROM index = current term index k.
- s4_in, s4_mult  out  1 each  x-register source select; s4_mult = ~s4_in.
- ld_x, ld_y, ld_tmp, ld_ans  out  1 each  datapath register loads.
- init_tmp, init_ans  out  1 each  datapath preset to 1.0 (0x0100).
- sub  out  1  add/sub select for ans.

Behaviour:
- Reset (rst_n=0, any time, including mid-run):
  - FSM goes to IDLE; k=0; terms=0.
  - busy, done, every ld_*, every init_*, sub, s1_rom, s2_x, s4_in and s3 are 0; s1_x, s2_tmp and s4_mult are 1.
  - Datapath register contents are not restored; the next LOAD re-presets them.
- Output timing: all control outputs are decoded from registered state and k only, so they are glitch-free. This matters because init_* are asynchronous presets in the datapath. No output depends combinationally on start or less_cmp.
- States (one clock each):
  - IDLE: if start, go to LOAD; otherwise stay.
  - LOAD: s4_in=1, ld_x=1, ld_y=1, init_tmp=1, init_ans=1; k cleared to 0. Go to SQR if SQUARE_X, else MUL_X.
  - SQR: s1_rom=0, s2_x=1, s4_in=0, ld_x=1 (x <= x*x). Go to MUL_X.
  - MUL_X: s1_rom=0, s2_x=0, ld_tmp=1 (tmp <= x*tmp). Go to MUL_C.
  - MUL_C: s1_rom=1, s3=k, s2_x=0, ld_tmp=1 (tmp <= rom[k]*tmp). Go to ACC.
  - ACC: ld_ans=1; sub = ALT_SIGN & ~k[0]; s3=k.
    - The current term is always accumulated.
    - less_cmp is valid here because tmp is stable after MUL_C.
    - If less_cmp=1 or k==MAX_TERMS-1: terms <= k+1, go to DONE.
    - Else k <= k+1, go to MUL_X.
  - DONE: done=1. Go to IDLE.
- Only one ld_* path to tmp or ans is active per cycle; init_* never coincide with ld_* for the same register.
- Latency from the start-sampling edge to the done-high cycle: 1 (LOAD) + SQUARE_X + 3*n + 1 cycles, where n is the number of terms accumulated.
- start while busy is ignored, not queued. start asserted in the DONE cycle is also ignored.
- k saturates at MAX_TERMS-1; s3 never exceeds MAX_TERMS-1.

Test Plan:
- Defaults, x=0x0100, in_y=0xFF, start pulse:
  - LOAD at cycle 1, MUL_X at 2, MUL_C at 3, ACC at 4 with less_cmp=1.
  - done at cycle 5 with terms=1, ans=0x0180.
  - busy high in cycles 1..5 and low in cycle 6.
- Defaults, x=0x0100, in_y=0:
  - tmp sequence 0x0080, 0x000C, 0x0000.
  - stop at k=2; terms=3, ans=0x018C, done at cycle 11.
- Defaults, x=0x0100, in_y=0, MAX_TERMS=2:
  - terminate on the limit with less_cmp=0; terms=2, ans=0x018C; s3 never exceeds 1.
- SQUARE_X=1, ALT_SIGN=1, x=0x0100, in_y=0xFF:
  - SQR cycle asserts ld_x with s2_x=1, s4_in=0.
  - sub=1 in ACC; ans=0x0080; terms=1; done at cycle 6.
- start re-pulsed in cycle 3 and again in the DONE cycle: neither starts a new run; FSM returns to IDLE and stays there.
- rst_n pulled low during MUL_C of the second term:
  - all outputs immediately take their reset values; terms=0.
  - a fresh start then runs the x=0x0100, in_y=0 case to terms=3 normally.

Source files
------------

// File: rtl/exp_series_ctrl.sv
// rtl/exp_series_ctrl.sv - Moore FSM sequencing the Q8.8 series-evaluation datapath
module exp_series_ctrl #(
  parameter int MAX_TERMS = 8,
  parameter bit SQUARE_X  = 1'b0,
  parameter bit ALT_SIGN  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       less_cmp,
  output logic       busy,
  output logic       done,
  output logic [3:0] terms,
  output logic       s1_rom,
  output logic       s1_x,
  output logic       s2_x,
  output logic       s2_tmp,
  output logic [2:0] s3,
  output logic       s4_in,
  output logic       s4_mult,
  output logic       ld_x,
  output logic       ld_y,
  output logic       ld_tmp,
  output logic       ld_ans,
  output logic       init_tmp,
  output logic       init_ans,
  output logic       sub
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SQR, S_MUL_X, S_MUL_C, S_ACC, S_DONE
  } state_t;

  localparam logic [2:0] K_LAST = 3'(MAX_TERMS - 1);

  state_t     state, state_nxt;
  logic [2:0] k, k_nxt;
  logic [3:0] terms_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= 3'd0;
      terms <= 4'd0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      terms <= terms_nxt;
    end
  end

  // Outputs decode only state and k, so init_* presets never see input-driven glitches.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    terms_nxt = terms;
    busy      = 1'b0;
    done      = 1'b0;
    s1_rom    = 1'b0;
    s2_x      = 1'b0;
    s3        = 3'd0;
    s4_in     = 1'b0;
    ld_x      = 1'b0;
    ld_y      = 1'b0;
    ld_tmp    = 1'b0;
    ld_ans    = 1'b0;
    init_tmp  = 1'b0;
    init_ans  = 1'b0;
    sub       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          terms_nxt = 4'd0;
        end
      end
      S_LOAD: begin
        busy      = 1'b1;
        s4_in     = 1'b1;
        ld_x      = 1'b1;
        ld_y      = 1'b1;
        init_tmp  = 1'b1;
        init_ans  = 1'b1;
        k_nxt     = 3'd0;
        state_nxt = SQUARE_X ? S_SQR : S_MUL_X;
      end
      S_SQR: begin
        busy      = 1'b1;
        s2_x      = 1'b1;
        ld_x      = 1'b1;
        state_nxt = S_MUL_X;
      end
      S_MUL_X: begin
        busy      = 1'b1;
        ld_tmp    = 1'b1;
        state_nxt = S_MUL_C;
      end
      S_MUL_C: begin
        busy      = 1'b1;
        s1_rom    = 1'b1;
        s3        = k;
        ld_tmp    = 1'b1;
        state_nxt = S_ACC;
      end
      S_ACC: begin
        busy   = 1'b1;
        ld_ans = 1'b1;
        s3     = k;
        sub    = ALT_SIGN & ~k[0];
        if (less_cmp || k >= K_LAST) begin
          terms_nxt = 4'(k) + 4'd1;
          state_nxt = S_DONE;
        end else begin
          k_nxt     = k + 3'd1;
          state_nxt = S_MUL_X;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign s1_x    = ~s1_rom;
  assign s2_tmp  = ~s2_x;
  assign s4_mult = ~s4_in;

endmodule

// File: tb/tb_exp_series_ctrl.sv
// tb/tb_exp_series_ctrl.sv - self-checking bench for exp_series_ctrl with a datapath model
module tb_exp_series_ctrl;

  localparam int NI = 3;
  localparam int MT [NI] = '{8, 2, 4};
  localparam bit SQ [NI] = '{1'b0, 1'b0, 1'b1};
  localparam bit AS [NI] = '{1'b0, 1'b0, 1'b1};

  typedef struct packed {
    logic       busy, done, s1_rom, s1_x, s2_x, s2_tmp;
    logic [2:0] s3;
    logic       s4_in, s4_mult, ld_x, ld_y, ld_tmp, ld_ans, init_tmp, init_ans, sub;
    logic [3:0] terms;
  } ctl_t;

  typedef struct packed {
    ctl_t        c;
    logic [15:0] ans;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] in_x, in_y;

  ctl_t        obs    [NI];
  logic        lc     [NI];
  logic [15:0] dp_ans [NI];

  exp_t        q [NI][$];
  bit          cur_idle  [NI];
  int          exp_terms [NI];
  int          start_cyc [NI];
  int          done_cyc  [NI];
  int          max_s3    [NI];
  int          cyc, vectors, miss;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_val(input int k);
    case (k)
      0:       return 16'h0080;
      1:       return 16'h0018;
      2:       return 16'h0002;
      default: return 16'h0001;
    endcase
  endfunction

  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return p[23:8];
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic        busy, done, s1_rom, s1_x, s2_x, s2_tmp, s4_in, s4_mult;
    logic        ld_x, ld_y, ld_tmp, ld_ans, init_tmp, init_ans, sub;
    logic [2:0]  s3;
    logic [3:0]  terms;
    logic [15:0] x, y, tmp, ans, op1, op2, mult;

    exp_series_ctrl #(.MAX_TERMS(MT[g]), .SQUARE_X(SQ[g]), .ALT_SIGN(AS[g])) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .less_cmp(lc[g]),
      .busy(busy), .done(done), .terms(terms),
      .s1_rom(s1_rom), .s1_x(s1_x), .s2_x(s2_x), .s2_tmp(s2_tmp), .s3(s3),
      .s4_in(s4_in), .s4_mult(s4_mult), .ld_x(ld_x), .ld_y(ld_y),
      .ld_tmp(ld_tmp), .ld_ans(ld_ans), .init_tmp(init_tmp), .init_ans(init_ans),
      .sub(sub)
    );

    assign obs[g] = {busy, done, s1_rom, s1_x, s2_x, s2_tmp, s3, s4_in, s4_mult,
                     ld_x, ld_y, ld_tmp, ld_ans, init_tmp, init_ans, sub, terms};

    // The datapath driven by the controller's pins; it closes the less_cmp loop.
    always_comb begin
      op1  = s1_rom ? rom_val(int'(s3)) : x;
      op2  = s2_x ? x : tmp;
      mult = qmul(op1, op2);
    end

    always_ff @(posedge clk) begin
      if (ld_x) x <= s4_in ? in_x : mult;
      if (ld_y) y <= in_y;
      if (init_tmp) tmp <= 16'h0100;
      else if (ld_tmp) tmp <= mult;
      if (init_ans) ans <= 16'h0100;
      else if (ld_ans) ans <= sub ? ans - tmp : ans + tmp;
    end

    assign lc[g]     = (tmp <= y);
    assign dp_ans[g] = ans;
  end

  function automatic ctl_t mk(input bit bz, dn, r1, x2, input logic [2:0] s3v,
                              input bit i4, lx, ly, lt, la, it, ia, sb,
                              input logic [3:0] tm);
    ctl_t c;
    c.busy = bz; c.done = dn; c.s1_rom = r1; c.s1_x = ~r1; c.s2_x = x2; c.s2_tmp = ~x2;
    c.s3 = s3v; c.s4_in = i4; c.s4_mult = ~i4; c.ld_x = lx; c.ld_y = ly; c.ld_tmp = lt;
    c.ld_ans = la; c.init_tmp = it; c.init_ans = ia; c.sub = sb; c.terms = tm;
    return c;
  endfunction

  function automatic ctl_t idle_ctl(input int i);
    return mk(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 4'(exp_terms[i]));
  endfunction

  // Series evaluated directly in Q8.8 arithmetic: terms accumulated and final ans.
  task automatic run_model(input int i, input logic [15:0] x, input logic [15:0] y,
                           output int n, output logic [15:0] a);
    logic [15:0] xv, t;
    xv = SQ[i] ? qmul(x, x) : x;
    t  = 16'h0100;
    a  = 16'h0100;
    n  = 0;
    for (int k = 0; k < MT[i]; k++) begin
      t = qmul(xv, t);
      t = qmul(rom_val(k), t);
      a = (AS[i] && (k % 2 == 0)) ? a - t : a + t;
      n = k + 1;
      if (t <= y) break;
    end
  endtask

  task automatic schedule(input int i);
    int          n;
    logic [15:0] a;
    exp_t        e;
    run_model(i, in_x, in_y, n, a);
    e.ans = a;
    e.c = mk(1, 0, 0, 0, 3'd0, 1, 1, 1, 0, 0, 1, 1, 0, 4'd0);
    q[i].push_back(e);
    if (SQ[i]) begin
      e.c = mk(1, 0, 0, 1, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0);
      q[i].push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      e.c = mk(1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 4'd0);
      q[i].push_back(e);
      e.c = mk(1, 0, 1, 0, 3'(k), 0, 0, 0, 1, 0, 0, 0, 0, 4'd0);
      q[i].push_back(e);
      e.c = mk(1, 0, 0, 0, 3'(k), 0, 0, 0, 0, 1, 0, 0, AS[i] && (k % 2 == 0), 4'd0);
      q[i].push_back(e);
    end
    e.c = mk(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 4'(n));
    q[i].push_back(e);
    exp_terms[i] = n;
    start_cyc[i] = cyc;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) q[i].delete();
      if (rst_n && q[i].size() > 0) e = q[i].pop_front();
      else begin
        e.c   = idle_ctl(i);
        e.ans = 16'h0;
      end
      cur_idle[i] = !e.c.busy;
      vectors++;
      if (obs[i] !== e.c) begin
        miss++;
        $display("FAIL ctl[%0d] cyc %0d: got %h want %h", i, cyc, obs[i], e.c);
      end
      if (e.c.done) begin
        done_cyc[i] = cyc - start_cyc[i];
        vectors++;
        if (dp_ans[i] !== e.ans) begin
          miss++;
          $display("FAIL ans_at_done[%0d] cyc %0d: got %h want %h", i, cyc, dp_ans[i], e.ans);
        end
      end
      if (int'(obs[i].s3) > max_s3[i]) max_s3[i] = int'(obs[i].s3);
    end
  endtask

  task automatic set_start(input bit v);
    start = v;
    if (v && rst_n)
      for (int i = 0; i < NI; i++)
        if (cur_idle[i]) schedule(i);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++) if (!cur_idle[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    while (!all_idle() && t < bound) begin
      tick();
      t++;
    end
    if (!all_idle()) begin
      miss++;
      $display("FAIL wait_idle: still busy after %0d cycles", bound);
    end
  endtask

  task automatic run(input logic [15:0] x, input logic [15:0] y);
    in_x = x;
    in_y = y;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    wait_idle(60);
  endtask

  initial begin
    int          n;
    logic [15:0] a;
    rst_n = 1'b0; start = 1'b0; in_x = 16'h0; in_y = 16'h0;
    cyc = 0; vectors = 0; miss = 0;
    for (int i = 0; i < NI; i++) begin
      cur_idle[i] = 1'b1; exp_terms[i] = 0; start_cyc[i] = 0; done_cyc[i] = 0; max_s3[i] = 0;
    end

    run_model(0, 16'h0100, 16'h00FF, n, a); chk("model0_y_ff_terms", n, 1); chk("model0_y_ff_ans", int'(a), 'h0180);
    run_model(0, 16'h0100, 16'h0000, n, a); chk("model0_y_0_terms", n, 3);  chk("model0_y_0_ans", int'(a), 'h018C);
    run_model(1, 16'h0100, 16'h0000, n, a); chk("model1_y_0_terms", n, 2);  chk("model1_y_0_ans", int'(a), 'h018C);
    run_model(2, 16'h0100, 16'h00FF, n, a); chk("model2_y_ff_terms", n, 1); chk("model2_y_ff_ans", int'(a), 'h0080);

    tick(); tick();
    rst_n = 1'b1;
    tick();

    run(16'h0100, 16'h00FF);
    chk("first_term_done_cycle", done_cyc[0], 5);
    chk("first_term_terms", int'(obs[0].terms), 1);
    chk("first_term_ans", int'(dp_ans[0]), 'h0180);
    chk("sqr_alt_done_cycle", done_cyc[2], 6);
    chk("sqr_alt_ans", int'(dp_ans[2]), 'h0080);

    for (int i = 0; i < NI; i++) max_s3[i] = 0;
    run(16'h0100, 16'h0000);
    chk("three_term_done_cycle", done_cyc[0], 11);
    chk("three_term_terms", int'(obs[0].terms), 3);
    chk("three_term_ans", int'(dp_ans[0]), 'h018C);
    chk("limit_terms", int'(obs[1].terms), 2);
    chk("limit_ans", int'(dp_ans[1]), 'h018C);
    chk("limit_max_s3", max_s3[1], 1);

    in_y = 16'h00FF;
    set_start(1'b1); tick(); set_start(1'b0);
    tick(); tick();
    set_start(1'b1); tick(); set_start(1'b0);
    tick();
    set_start(1'b1); tick(); set_start(1'b0);
    repeat (5) tick();
    for (int i = 0; i < NI; i++) chk($sformatf("ignored_start_busy%0d", i), int'(obs[i].busy), 0);

    in_y = 16'h0000;
    set_start(1'b1); tick(); set_start(1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      q[i].delete(); exp_terms[i] = 0; cur_idle[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (obs[i] !== idle_ctl(i)) begin
        miss++;
        $display("FAIL async_reset[%0d]: got %h want %h", i, obs[i], idle_ctl(i));
      end
    end
    tick();
    rst_n = 1'b1;
    tick();
    run(16'h0100, 16'h0000);
    chk("after_reset_terms", int'(obs[0].terms), 3);
    chk("after_reset_ans", int'(dp_ans[0]), 'h018C);

    for (int it = 0; it < 60; it++) begin
      int t;
      in_x = 16'($urandom_range(16'h0080, 16'h0300));
      in_y = 16'($urandom_range(0, 16'h0040));
      set_start(1'b1);
      tick();
      t = 0;
      while (t < 60) begin
        set_start($urandom_range(0, 3) == 0);
        tick();
        t++;
        if (all_idle() && !start) break;
      end
      set_start(1'b0);
      wait_idle(60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
